// File: rtl/next_pc_mt.sv
// next_pc_mt: per-thread PC registers with prioritized redirects and round-robin fetch arbitration.
// Define NEXT_PC_MT_PERF_EN to enable the saturating redirect event counter on redirect_cnt_o.
module next_pc_mt #(
    parameter int VLEN = 64,
    parameter int NR_THREADS = 2,
    parameter int FETCH_ALIGN_BITS = 2,
    parameter logic [63:0] DM_HALT_ADDR = 64'h800,
    localparam int TID_W = NR_THREADS > 1 ? $clog2(NR_THREADS) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [VLEN-1:0]       boot_addr_i,
    input  logic [NR_THREADS-1:0] thread_en_i,
    input  logic                  fetch_ready_i,
    output logic                  fetch_valid_o,
    output logic [VLEN-1:0]       fetch_addr_o,
    output logic [TID_W-1:0]      fetch_tid_o,
    input  logic                  bp_valid_i,
    input  logic [TID_W-1:0]      bp_tid_i,
    input  logic [VLEN-1:0]       bp_addr_i,
    input  logic                  replay_valid_i,
    input  logic [TID_W-1:0]      replay_tid_i,
    input  logic [VLEN-1:0]       replay_addr_i,
    input  logic                  mispredict_valid_i,
    input  logic [TID_W-1:0]      mispredict_tid_i,
    input  logic [VLEN-1:0]       mispredict_addr_i,
    input  logic                  eret_valid_i,
    input  logic [TID_W-1:0]      eret_tid_i,
    input  logic [VLEN-1:0]       eret_addr_i,
    input  logic                  ex_valid_i,
    input  logic [TID_W-1:0]      ex_tid_i,
    input  logic [VLEN-1:0]       ex_addr_i,
    input  logic                  commit_valid_i,
    input  logic [TID_W-1:0]      commit_tid_i,
    input  logic [VLEN-1:0]       commit_pc_i,
    input  logic                  commit_halt_i,
    input  logic                  debug_valid_i,
    input  logic [TID_W-1:0]      debug_tid_i,
    output logic [31:0]           redirect_cnt_o
);
    typedef enum logic [1:0] {BOOT, RUN, PARKED} state_t;

    localparam logic [VLEN-1:0] STEP = VLEN'(1) << FETCH_ALIGN_BITS;
    localparam logic [VLEN-1:0] HALT = DM_HALT_ADDR[VLEN-1:0];

    state_t                st_q [NR_THREADS];
    logic [VLEN-1:0]       pc_q [NR_THREADS];
    logic [VLEN-1:0]       pc_d [NR_THREADS];
    logic [NR_THREADS-1:0] elig;
    logic [TID_W-1:0]      rr_q, hold_q, sel;
    logic                  lock_q, valid, accept;

    function automatic logic hit(input logic v, input logic [TID_W-1:0] tid, input int t);
        return v && tid == TID_W'(t);
    endfunction

    always_comb begin
        for (int t = 0; t < NR_THREADS; t++)
            elig[t] = st_q[t] == RUN && thread_en_i[t];
    end

    // A held request keeps its thread; otherwise scan from rr_q, lowest offset wins.
    always_comb begin
        int j;
        j = 0;
        valid = 1'b0;
        sel = '0;
        if (lock_q && elig[hold_q]) begin
            valid = 1'b1;
            sel = hold_q;
        end else begin
            for (int i = NR_THREADS - 1; i >= 0; i--) begin
                j = int'(rr_q) + i;
                if (j >= NR_THREADS) j = j - NR_THREADS;
                if (elig[j]) begin
                    valid = 1'b1;
                    sel = TID_W'(j);
                end
            end
        end
    end

    assign accept        = valid && fetch_ready_i;
    assign fetch_valid_o = valid;
    assign fetch_addr_o  = valid ? pc_q[sel] : '0;
    assign fetch_tid_o   = valid ? sel : '0;

    always_comb begin
        for (int t = 0; t < NR_THREADS; t++)
            pc_d[t] = hit(debug_valid_i, debug_tid_i, t) ? HALT :
                      hit(commit_valid_i, commit_tid_i, t) ? commit_pc_i + (commit_halt_i ? '0 : VLEN'(4)) :
                      hit(ex_valid_i, ex_tid_i, t) ? ex_addr_i :
                      hit(eret_valid_i, eret_tid_i, t) ? eret_addr_i :
                      hit(mispredict_valid_i, mispredict_tid_i, t) ? mispredict_addr_i :
                      hit(replay_valid_i, replay_tid_i, t) ? replay_addr_i :
                      hit(bp_valid_i, bp_tid_i, t) ? bp_addr_i :
                      (accept && sel == TID_W'(t)) ? (pc_q[t] & ~(STEP - VLEN'(1))) + STEP : pc_q[t];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q <= '0;
            hold_q <= '0;
            lock_q <= 1'b0;
            for (int t = 0; t < NR_THREADS; t++) begin
                pc_q[t] <= '0;
                st_q[t] <= BOOT;
            end
        end else begin
            lock_q <= valid && !fetch_ready_i;
            hold_q <= sel;
            if (accept) rr_q <= sel == TID_W'(NR_THREADS - 1) ? '0 : sel + TID_W'(1);
            for (int t = 0; t < NR_THREADS; t++) begin
                if (st_q[t] == BOOT) begin
                    pc_q[t] <= boot_addr_i;
                    st_q[t] <= RUN;
                end else begin
                    pc_q[t] <= pc_d[t];
                    st_q[t] <= thread_en_i[t] ? RUN : PARKED;
                end
            end
        end
    end

`ifdef NEXT_PC_MT_PERF_EN
    logic [NR_THREADS-1:0] redir;
    logic [31:0]           cnt_q;

    always_comb begin
        for (int t = 0; t < NR_THREADS; t++)
            redir[t] = st_q[t] != BOOT && (hit(debug_valid_i, debug_tid_i, t) ||
                       hit(commit_valid_i, commit_tid_i, t) || hit(ex_valid_i, ex_tid_i, t) ||
                       hit(eret_valid_i, eret_tid_i, t) || hit(mispredict_valid_i, mispredict_tid_i, t) ||
                       hit(replay_valid_i, replay_tid_i, t) || hit(bp_valid_i, bp_tid_i, t));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else if (|redir && !(&cnt_q)) cnt_q <= cnt_q + 32'd1;
    end

    assign redirect_cnt_o = cnt_q;
`else
    assign redirect_cnt_o = '0;
`endif
endmodule

// File: tb/tb_next_pc_mt.sv
// tb_next_pc_mt: directed stimulus with a scoreboard of expected accepted fetches (tid, addr).
module tb_next_pc_mt;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] boot_addr;
    logic [1:0]  thread_en;
    logic        fetch_ready, fetch_valid;
    logic [63:0] fetch_addr;
    logic        fetch_tid;
    logic        bp_valid, replay_valid, mp_valid, eret_valid, ex_valid, commit_valid, commit_halt, debug_valid;
    logic        bp_tid, replay_tid, mp_tid, eret_tid, ex_tid, commit_tid, debug_tid;
    logic [63:0] bp_addr, replay_addr, mp_addr, eret_addr, ex_addr, commit_pc;
    logic [31:0] redirect_cnt;
    logic [64:0] sbq [$];
    logic        mon_en = 1'b0;
    int          n_chk = 0;
    int          n_pass = 0;

    always #5 clk = ~clk;

    next_pc_mt dut (
        .clk_i(clk), .rst_ni(rst_n), .boot_addr_i(boot_addr), .thread_en_i(thread_en),
        .fetch_ready_i(fetch_ready), .fetch_valid_o(fetch_valid), .fetch_addr_o(fetch_addr), .fetch_tid_o(fetch_tid),
        .bp_valid_i(bp_valid), .bp_tid_i(bp_tid), .bp_addr_i(bp_addr),
        .replay_valid_i(replay_valid), .replay_tid_i(replay_tid), .replay_addr_i(replay_addr),
        .mispredict_valid_i(mp_valid), .mispredict_tid_i(mp_tid), .mispredict_addr_i(mp_addr),
        .eret_valid_i(eret_valid), .eret_tid_i(eret_tid), .eret_addr_i(eret_addr),
        .ex_valid_i(ex_valid), .ex_tid_i(ex_tid), .ex_addr_i(ex_addr),
        .commit_valid_i(commit_valid), .commit_tid_i(commit_tid), .commit_pc_i(commit_pc), .commit_halt_i(commit_halt),
        .debug_valid_i(debug_valid), .debug_tid_i(debug_tid), .redirect_cnt_o(redirect_cnt)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic push(input logic tid, input logic [63:0] addr);
        sbq.push_back({tid, addr});
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        {bp_valid, replay_valid, mp_valid, eret_valid, ex_valid, commit_valid, commit_halt, debug_valid} = '0;
        {bp_tid, replay_tid, mp_tid, eret_tid, ex_tid, commit_tid, debug_tid} = '0;
        {bp_addr, replay_addr, mp_addr, eret_addr, ex_addr, commit_pc} = '0;
    endtask

    always @(negedge clk) begin
        if (mon_en && fetch_valid && fetch_ready) begin
            if (sbq.size() == 0) check("sb_extra_fetch", 64'(fetch_tid), 64'hdead);
            else begin
                logic [64:0] e;
                e = sbq.pop_front();
                check("sb_tid", 64'(fetch_tid), 64'(e[64]));
                check("sb_addr", fetch_addr, e[63:0]);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        clr();
        rst_n = 1'b0;
        fetch_ready = 1'b1;
        thread_en = 2'b11;
        boot_addr = 64'h8000_0000;
        #2;
        check("rst_valid", 64'(fetch_valid), 0);
        check("rst_addr", fetch_addr, 0);
        check("rst_tid", 64'(fetch_tid), 0);
        check("rst_cnt", 64'(redirect_cnt), 0);
        #5 rst_n = 1'b1;
        #5 check("boot_valid", 64'(fetch_valid), 0);
        cyc();
        mon_en = 1'b1;
        push(0, 64'h8000_0000); push(1, 64'h8000_0000); push(0, 64'h8000_0004);
        push(1, 64'h8000_0004); push(0, 64'h8000_0008);
        repeat (5) cyc();
        fetch_ready = 1'b0;
        repeat (3) begin
            #3;
            check("stall_valid", 64'(fetch_valid), 1);
            check("stall_tid", 64'(fetch_tid), 1);
            check("stall_addr", fetch_addr, 64'h8000_0008);
            cyc();
        end
        fetch_ready = 1'b1;
        push(1, 64'h8000_0008);
        cyc();
        push(0, 64'h8000_000C);
        mp_valid = 1'b1; mp_tid = 1'b0; mp_addr = 64'h100;
        ex_valid = 1'b1; ex_tid = 1'b0; ex_addr = 64'h200;
        bp_valid = 1'b1; bp_tid = 1'b1; bp_addr = 64'h400;
        #3 check("grant_after_stall", 64'(fetch_tid), 0);
        cyc(); clr(); push(1, 64'h400);
        cyc(); push(0, 64'h200);
        commit_valid = 1'b1; commit_tid = 1'b1; commit_pc = 64'h3000;
        cyc(); push(1, 64'h3004);
        commit_halt = 1'b1;
        cyc(); push(0, 64'h204);
        commit_halt = 1'b0; debug_valid = 1'b1; debug_tid = 1'b1;
        cyc(); clr(); push(1, 64'h800);
`ifdef NEXT_PC_MT_PERF_EN
        #3 check("redirect_cnt", 64'(redirect_cnt), 4);
`else
        #3 check("redirect_cnt", 64'(redirect_cnt), 0);
`endif
        cyc(); push(0, 64'h208);
        thread_en = 2'b01;
        cyc(); push(0, 64'h20C);
        bp_valid = 1'b1; bp_tid = 1'b1; bp_addr = 64'h400;
        #3 check("parked_tid", 64'(fetch_tid), 0);
        cyc(); clr(); push(0, 64'h210);
        cyc(); push(0, 64'h214);
        thread_en = 2'b11;
        cyc(); push(1, 64'h400);
        cyc(); push(0, 64'h218);
        ex_valid = 1'b1; ex_tid = 1'b0; ex_addr = 64'hFFFF_FFFF_FFFF_FFFC;
        cyc(); clr(); push(1, 64'h404);
        cyc(); push(0, 64'hFFFF_FFFF_FFFF_FFFC);
        cyc(); push(1, 64'h408);
        cyc(); push(0, 64'h0);
        cyc();
        fetch_ready = 1'b0;
        #3;
        check("stall2_valid", 64'(fetch_valid), 1);
        check("stall2_tid", 64'(fetch_tid), 1);
        check("stall2_addr", fetch_addr, 64'h40C);
        cyc();
        #2;
        mon_en = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 64'(fetch_valid), 0);
        check("midrst_addr", fetch_addr, 0);
        check("midrst_cnt", 64'(redirect_cnt), 0);
        check("sb_empty", 64'(sbq.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/next_pc_mt.md
Name: next_pc_mt

Overview:
Multi-thread next-PC generator for the CVA6 frontend. Holds one PC register per hardware thread and applies thread-tagged redirects from the predictor, frontend replay and backend using a fixed priority. Arbitrates fetch among enabled threads with round-robin and issues a valid/ready fetch request carrying address and thread id to the instruction frontend.

Parameters:
VLEN, 64, virtual address width
NR_THREADS, 2, number of hardware threads (>=1)
FETCH_ALIGN_BITS, 2, log2 of fetch block bytes; sequential increment is block-aligned
DM_HALT_ADDR, 64'h800, debug halt entry address (low VLEN bits used)
TID_W (localparam), max(1,$clog2(NR_THREADS)), thread id width

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
boot_addr_i  in  VLEN  boot address, loaded into every thread in BOOT state
thread_en_i  in  NR_THREADS  per-thread fetch enable
fetch_ready_i  in  1  frontend accepts request
fetch_valid_o  out  1  fetch request valid
fetch_addr_o  out  VLEN  fetch address
fetch_tid_o  out  TID_W  fetch thread id
bp_valid_i / bp_tid_i / bp_addr_i  in  1/TID_W/VLEN  predicted-taken redirect
replay_valid_i / replay_tid_i / replay_addr_i  in  1/TID_W/VLEN  frontend replay
mispredict_valid_i / mispredict_tid_i / mispredict_addr_i  in  1/TID_W/VLEN  resolved-branch target
eret_valid_i / eret_tid_i / eret_addr_i  in  1/TID_W/VLEN  exception-return PC
ex_valid_i / ex_tid_i / ex_addr_i  in  1/TID_W/VLEN  trap vector base
commit_valid_i / commit_tid_i / commit_pc_i / commit_halt_i  in  1/TID_W/VLEN/1  CSR-side-effect flush
debug_valid_i / debug_tid_i  in  1/TID_W  debug entry
redirect_cnt_o  out  32  redirect event counter (optional feature)

Behaviour:
- Reset (async, immediate): pc_q[t]=0, state[t]=BOOT, rr_q=0, lock_q=0; fetch_valid_o=0, fetch_addr_o=0, fetch_tid_o=0, redirect_cnt_o=0.
- Per-thread FSM: BOOT -> RUN on first clock after reset, loading pc_q[t]=boot_addr_i (redirects ignored in BOOT). RUN -> PARKED when thread_en_i[t]=0; PARKED -> RUN when thread_en_i[t]=1. PARKED threads do not fetch but still accept redirects.
- Per-thread next-PC priority, highest first: debug (DM_HALT_ADDR) > commit (commit_pc_i + (commit_halt_i ? 0 : 4)) > ex > eret > mispredict > replay > bp > sequential. Sequential applies only on accept of that thread: {pc_q[VLEN-1:FETCH_ALIGN_BITS]+1, FETCH_ALIGN_BITS'0}. All arithmetic modulo 2^VLEN (wraps to 0).
- Redirects to different tids in the same cycle apply independently. A tid >= NR_THREADS is ignored.
- All updates are registered: a redirect in cycle N is visible on fetch_addr_o in cycle N+1.
- Arbitration: eligible = RUN && thread_en_i. If lock_q=0, pick the first eligible thread starting at rr_q, wrapping. fetch_valid_o=1 iff a thread is selected. fetch_addr_o=pc_q[sel], fetch_tid_o=sel; both 0 when not valid.
- Handshake: valid && !ready sets lock_q to hold sel; tid stays stable until accepted. If that thread is redirected while held, addr changes next cycle and valid stays high. If that thread leaves eligibility while held, lock drops and valid may deassert. On accept: rr_q <= sel+1 mod NR_THREADS, lock_q <= 0.

Optional Feature:
NEXT_PC_MT_PERF_EN: when defined, redirect_cnt_o increments by 1 in each cycle in which at least one non-sequential update is applied to any thread. It saturates at 32'hFFFF_FFFF and is cleared by reset. When not defined, redirect_cnt_o is tied to 0 and no counter flop exists.

Test Plan:
1. NR_THREADS=2, boot 0x8000_0000, en=2'b11, ready=1 -> cycle 1 after reset valid=0. Then fetches are tid0@0x8000_0000, tid1@0x8000_0000, tid0@0x8000_0004, tid1@0x8000_0004.
2. ready=0 for 3 cycles with tid1 selected -> valid=1, tid=1, addr stable. After ready=1 the next grant is tid0.
3. Same cycle: mispredict tid0 0x100, ex tid0 0x200, accept of tid0 -> next tid0 addr 0x200. A simultaneous bp tid1 0x400 gives tid1 addr 0x400.
4. commit tid1 pc 0x3000 halt=0 -> 0x3004. With halt=1 -> 0x3000. commit plus debug to tid1 in the same cycle -> 0x800.
5. en=2'b01 -> only tid0 fetched. bp tid1 0x400 while PARKED, then en=2'b11 -> tid1 fetches 0x400.
6. pc0=0xFFFF_FFFF_FFFF_FFFC accepted -> 0x0. Assert rst_ni mid-stall -> fetch_valid_o=0 immediately, and with PERF_EN redirect_cnt_o=0.
